// File: rtl/mod_addsub_pipe.sv
// Two-stage pipelined modular adder/subtractor built on two CLA32 adders.
// Define MODADD_RANGE_CHK_EN to add the range_err output.

module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [7:0]  gg;
  logic [7:0]  gp;
  logic [8:0]  gc;

  // 4-bit groups, lookahead across groups, ripple inside a group
  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int j = 0; j < 8; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1]
               & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    gc[0] = c_in;
    for (int j = 0; j < 8; j++) begin
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end
    for (int j = 0; j < 8; j++) begin
      c[4*j] = gc[j];
      for (int k = 1; k < 4; k++) begin
        c[4*j+k] = g[4*j+k-1]
                 | (p[4*j+k-1] & c[4*j+k-1]);
      end
    end
    sum   = p ^ c;
    c_out = gc[8];
  end

endmodule

module mod_addsub_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op_sub,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic [DATA_WIDTH-1:0] mod_in,
  input  logic [TAG_WIDTH-1:0]  tag_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] res_out,
`ifdef MODADD_RANGE_CHK_EN
  output logic                  range_err,
`endif
  output logic [TAG_WIDTH-1:0]  tag_out
);

  typedef struct packed {
    logic [31:0]          sum;
    logic                 c;
    logic                 op;
    logic [31:0]          p;
    logic [TAG_WIDTH-1:0] tag;
  } s1_t;

  logic v1;
  logic v2;
  logic adv1;
  logic adv2;
  s1_t  s1;

  logic [31:0] b_x;
  logic [31:0] sum_a;
  logic        c_a;

  logic [31:0] corr;
  logic        cin2;
  logic [31:0] t;
  logic        ct;
  logic [31:0] res_nxt;

  assign adv2     = !v2 || out_ready;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;
  assign out_valid = v2;

  assign b_x = op_sub ? ~b_in : b_in;

  cla32 u_cla_s1 (
    .a     (a_in),
    .b     (b_x),
    .c_in  (op_sub),
    .sum   (sum_a),
    .c_out (c_a)
  );

  // add subtracts p (sum1 + ~p + 1); sub adds p back
  assign corr = s1.op ? s1.p : ~s1.p;
  assign cin2 = !s1.op;

  cla32 u_cla_s2 (
    .a     (s1.sum),
    .b     (corr),
    .c_in  (cin2),
    .sum   (t),
    .c_out (ct)
  );

  always_comb begin
    res_nxt = s1.sum;
    if (s1.op) begin
      if (!s1.c) res_nxt = t;
    end else begin
      if (s1.c || ct) res_nxt = t;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      s1 <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1.sum <= sum_a;
        s1.c   <= c_a;
        s1.op  <= op_sub;
        s1.p   <= mod_in;
        s1.tag <= tag_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2      <= 1'b0;
      res_out <= '0;
      tag_out <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        res_out <= res_nxt;
        tag_out <= s1.tag;
      end
    end
  end

`ifdef MODADD_RANGE_CHK_EN
  logic err1;
  logic err_nxt;

  assign err_nxt = (a_in >= mod_in)
                || (b_in >= mod_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err1      <= 1'b0;
      range_err <= 1'b0;
    end else begin
      if (adv1 && in_valid) err1 <= err_nxt;
      if (adv2 && v1) range_err <= err1;
    end
  end
`endif

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Directed self-checking bench for mod_addsub_pipe.
// Build with MODADD_RANGE_CHK_EN to also exercise range_err.

module tb_mod_addsub_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        op_sub;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] mod_in;
  logic [3:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res_out;
  logic [3:0]  tag_out;
`ifdef MODADD_RANGE_CHK_EN
  logic        range_err;
`endif

  int n_cmp;
  int n_err;

  mod_addsub_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a_in      (a_in),
    .b_in      (b_in),
    .mod_in    (mod_in),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_out   (res_out),
`ifdef MODADD_RANGE_CHK_EN
    .range_err (range_err),
`endif
    .tag_out   (tag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one op through an idle pipe, exact 2-register latency
  task automatic single(input string name,
                        input logic op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] p,
                        input logic [3:0] tg,
                        input logic [31:0] exp);
    in_valid = 1'b1;
    op_sub = op;
    a_in = a;
    b_in = b;
    mod_in = p;
    tag_in = tg;
    #1;
    chk({name, "_in_ready"}, 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk({name, "_early"}, 32'(out_valid), 0);
    tick();
    chk({name, "_valid"}, 32'(out_valid), 1);
    chk({name, "_res"}, res_out, exp);
    chk({name, "_tag"}, 32'(tag_out), 32'(tg));
    tick();
    chk({name, "_drain"}, 32'(out_valid), 0);
  endtask

  logic [31:0] exp_bb [8];
  logic [31:0] exp_st [6];
  int sent;
  int rcv;
  logic fire_in;
  logic fire_out;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    op_sub = 1'b0;
    a_in = '0;
    b_in = '0;
    mod_in = '0;
    tag_in = '0;
    out_ready = 1'b1;
    exp_bb = '{3, 5, 7, 9, 11, 13, 15, 0};
    exp_st = '{10, 9, 8, 7, 6, 5};

    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_res", res_out, 0);
    chk("rst_tag", 32'(tag_out), 0);
`ifdef MODADD_RANGE_CHK_EN
    chk("rst_range_err", 32'(range_err), 0);
`endif
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", 32'(in_ready), 1);

    single("add_10_9", 0, 10, 9, 17, 1, 2);
    single("add_8_8", 0, 8, 8, 17, 2, 16);
    single("add_9_8", 0, 9, 8, 17, 3, 0);
    single("sub_3_5", 1, 3, 5, 17, 4, 15);
    single("sub_5_3", 1, 5, 3, 17, 5, 2);
    single("sub_7_7", 1, 7, 7, 17, 6, 0);
    single("add_big", 0, 32'hFFFF_FFFA,
           32'hFFFF_FFFA, 32'hFFFF_FFFB,
           7, 32'hFFFF_FFF9);
    single("sub_big", 1, 0, 32'hFFFF_FFFA,
           32'hFFFF_FFFB, 8, 1);
`ifdef MODADD_RANGE_CHK_EN
    chk("rerr_ok", 32'(range_err), 0);
`endif

    // 8 back-to-back adds, out_ready held high
    for (int s = 0; s < 9; s++) begin
      in_valid = (s < 8);
      op_sub = 1'b0;
      a_in = 32'(s);
      b_in = 32'(s + 3);
      mod_in = 17;
      tag_in = 4'(s);
      #1;
      if (s < 8) chk("bb_in_ready", 32'(in_ready), 1);
      tick();
      if (s == 0) begin
        chk("bb_first_early", 32'(out_valid), 0);
      end else begin
        chk("bb_valid", 32'(out_valid), 1);
        chk("bb_res", res_out, exp_bb[s-1]);
        chk("bb_tag", 32'(tag_out), 32'(s - 1));
      end
    end
    in_valid = 1'b0;
    tick();
    chk("bb_drained", 32'(out_valid), 0);

    // 6 subs with a 5-cycle consumer stall
    sent = 0;
    rcv = 0;
    for (int c = 0; c < 15; c++) begin
      in_valid = (sent < 6);
      op_sub = 1'b1;
      a_in = 10;
      b_in = 32'(sent);
      mod_in = 17;
      tag_in = 4'(8 + sent);
      out_ready = !(c >= 2 && c <= 6);
      #1;
      if (c <= 10)
        chk("st_in_ready", 32'(in_ready),
            32'(!(c >= 2 && c <= 6)));
      if (c >= 2 && c <= 6)
        chk("st_held_valid", 32'(out_valid), 1);
      if (out_valid && rcv < 6) begin
        chk("st_res", res_out, exp_st[rcv]);
        chk("st_tag", 32'(tag_out), 32'(8 + rcv));
      end
      fire_in = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      @(posedge clk);
      if (fire_in) sent++;
      if (fire_out) rcv++;
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("st_sent", 32'(sent), 6);
    chk("st_rcvd", 32'(rcv), 6);
    chk("st_empty", 32'(out_valid), 0);

    // reset with two ops in flight
    in_valid = 1'b1;
    op_sub = 1'b0;
    a_in = 1;
    b_in = 2;
    mod_in = 17;
    tag_in = 4'hA;
    tick();
    a_in = 4;
    tag_in = 4'hB;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_res", res_out, 0);
    chk("arst_tag", 32'(tag_out), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(out_valid), 0);
    single("post_rst", 0, 16, 16, 17, 4'hC, 15);

`ifdef MODADD_RANGE_CHK_EN
    in_valid = 1'b1;
    op_sub = 1'b0;
    a_in = 17;
    b_in = 0;
    mod_in = 17;
    tag_in = 4'hD;
    tick();
    in_valid = 1'b0;
    tick();
    chk("rerr_valid", 32'(out_valid), 1);
    chk("rerr_flag", 32'(range_err), 1);
    chk("rerr_res", res_out, 0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
